// File: rtl/song_sequencer.sv
// song_sequencer: song-position time base for the phrase-ID lookup stage.
//   Tempo tick divider -> step counter within a phrase -> phrase counter walking
//   song positions 1..LAST_ADDR, with optional wrap to LOOP_ADDR.
// Ports:
//   clk, rst_n      single clock, asynchronous active-low reset
//   start, stop     level controls sampled every cycle; stop wins over start
//   loop_en         sampled when the last phrase ends; high wraps to LOOP_ADDR
//   phrase_addr     song position to the lookup stage (0 = silence)
//   step            step index within the current phrase
//   step_strobe     pulse on the first cycle of each step
//   phrase_strobe   pulse on the first cycle of each phrase
//   playing, done   state flags for PLAY / DONE
module song_sequencer #(
    parameter int unsigned TICK_DIV         = 12500,
    parameter int unsigned STEPS_PER_PHRASE = 16,
    parameter int unsigned LAST_ADDR        = 152,
    parameter int unsigned LOOP_ADDR        = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       loop_en,
    output logic [7:0] phrase_addr,
    output logic [3:0] step,
    output logic       step_strobe,
    output logic       phrase_strobe,
    output logic       playing,
    output logic       done
);

    localparam logic [15:0] TickLast = 16'(TICK_DIV - 1);
    localparam logic [3:0]  StepLast = 4'(STEPS_PER_PHRASE - 1);
    localparam logic [7:0]  LastAddr = 8'(LAST_ADDR);
    localparam logic [7:0]  LoopAddr = 8'(LOOP_ADDR);

    typedef enum logic [1:0] {StIdle, StPlay, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] tick_q, tick_d;
    logic [3:0]  step_q, step_d;
    logic [7:0]  addr_q, addr_d;
    logic        sstb_q, sstb_d;
    logic        pstb_q, pstb_d;
    logic        playing_q, playing_d;
    logic        done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            tick_q    <= '0;
            step_q    <= '0;
            addr_q    <= '0;
            sstb_q    <= 1'b0;
            pstb_q    <= 1'b0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            step_q    <= step_d;
            addr_q    <= addr_d;
            sstb_q    <= sstb_d;
            pstb_q    <= pstb_d;
            playing_q <= playing_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        step_d  = step_q;
        addr_d  = addr_q;
        sstb_d  = 1'b0;
        pstb_d  = 1'b0;

        if (stop) begin
            state_d = StIdle;
            tick_d  = '0;
            step_d  = '0;
            addr_d  = '0;
        end else if (start) begin
            // Start, restart and start-from-DONE are all the same fresh launch.
            state_d = StPlay;
            tick_d  = '0;
            step_d  = '0;
            addr_d  = 8'd1;
            sstb_d  = 1'b1;
            pstb_d  = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    tick_d = '0;
                    step_d = '0;
                    addr_d = '0;
                end
                StPlay: begin
                    if (tick_q == TickLast) begin
                        tick_d = '0;
                        sstb_d = 1'b1;
                        if (step_q == StepLast) begin
                            step_d = '0;
                            pstb_d = 1'b1;
                            if (addr_q < LastAddr) begin
                                addr_d = addr_q + 8'd1;
                            end else if (loop_en) begin
                                addr_d = LoopAddr;
                            end else begin
                                // Song over: silence, and no strobes on entry to DONE.
                                state_d = StDone;
                                addr_d  = '0;
                                sstb_d  = 1'b0;
                                pstb_d  = 1'b0;
                            end
                        end else begin
                            step_d = step_q + 4'd1;
                        end
                    end else begin
                        tick_d = tick_q + 16'd1;
                    end
                end
                StDone: ;
                default: begin
                    state_d = StIdle;
                    tick_d  = '0;
                    step_d  = '0;
                    addr_d  = '0;
                end
            endcase
        end

        playing_d = (state_d == StPlay);
        done_d    = (state_d == StDone);
    end

    assign phrase_addr   = addr_q;
    assign step          = step_q;
    assign step_strobe   = sstb_q;
    assign phrase_strobe = pstb_q;
    assign playing       = playing_q;
    assign done          = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
module tb_song_sequencer;

    localparam int TD   = 4;
    localparam int SPP  = 4;
    localparam int LAST = 3;
    localparam int LOOP = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop_en = 1'b0;
    logic [7:0] phrase_addr;
    logic [3:0] step;
    logic       step_strobe;
    logic       phrase_strobe;
    logic       playing;
    logic       done;

    song_sequencer #(
        .TICK_DIV        (TD),
        .STEPS_PER_PHRASE(SPP),
        .LAST_ADDR       (LAST),
        .LOOP_ADDR       (LOOP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .loop_en      (loop_en),
        .phrase_addr  (phrase_addr),
        .step         (step),
        .step_strobe  (step_strobe),
        .phrase_strobe(phrase_strobe),
        .playing      (playing),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] addr;
        logic [3:0] step;
        logic       ss;
        logic       ps;
        logic       play;
        logic       dn;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Reference model: mode plus cycles elapsed since the launching edge.
    int m_mode = 0;  // 0 idle, 1 play, 2 done
    int m_e    = 0;
    bit m_loop = 1'b0;
    bit cur_loop = 1'b0;

    function automatic exp_t model_out();
        exp_t r;
        int   p;
        r = '0;
        if (m_mode == 1) begin
            p      = m_e / (TD * SPP);
            r.play = 1'b1;
            r.step = 4'((m_e / TD) % SPP);
            r.ss   = (m_e % TD) == 0;
            r.ps   = (m_e % (TD * SPP)) == 0;
            r.addr = (p < LAST) ? 8'(p + 1) : 8'(LOOP + (p - LAST) % (LAST - LOOP + 1));
        end else if (m_mode == 2) begin
            r.dn = 1'b1;
        end
        return r;
    endfunction

    task automatic check(input string name, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got addr=%0d step=%0d ss=%0b ps=%0b play=%0b done=%0b, want addr=%0d step=%0d ss=%0b ps=%0b play=%0b done=%0b",
                     name, $time, act.addr, act.step, act.ss, act.ps, act.play, act.dn,
                     exp.addr, exp.step, exp.ss, exp.ps, exp.play, exp.dn);
        end
    endtask

    function automatic exp_t dut_out();
        exp_t r;
        r.addr = phrase_addr;
        r.step = step;
        r.ss   = step_strobe;
        r.ps   = phrase_strobe;
        r.play = playing;
        r.dn   = done;
        return r;
    endfunction

    // One cycle of stimulus: drive inputs, advance the model, queue the expectation.
    task automatic cyc(input bit st, input bit sp, input bit lp);
        @(negedge clk);
        start   = st;
        stop    = sp;
        loop_en = lp;
        if (sp) begin
            m_mode = 0;
        end else if (st) begin
            m_mode = 1;
            m_e    = 0;
            m_loop = lp;
        end else if (m_mode == 1) begin
            m_e++;
            if (m_e >= LAST * TD * SPP && !m_loop) m_mode = 2;
        end
        q.push_back(model_out());
        mon_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, cur_loop);
    endtask

    task automatic launch(input bit lp);
        cur_loop = lp;
        cyc(1'b1, 1'b0, lp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("async_reset", dut_out(), exp_t'('0));
        q.delete();
        m_mode = 0;
        m_e    = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every cycle is an output beat; pop and compare.
    always @(posedge clk) begin
        if (mon_en) begin
            #1;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty @%0t: got no expectation, want one", $time);
            end else begin
                check("cycle", dut_out(), q.pop_front());
            end
        end
    end

    initial begin
        #1;
        check("reset_state", dut_out(), exp_t'('0));
        @(negedge clk);
        rst_n = 1'b1;

        idle(100);                       // no start: stays silent
        launch(1'b0);                    // basic play, end without loop
        idle(60);                        // DONE reached and held
        launch(1'b1);                    // start from DONE, looping
        idle(110);
        launch(1'b0);                    // stop mid-phrase 2
        idle(20);
        cyc(1'b0, 1'b1, cur_loop);
        idle(5);
        launch(1'b0);                    // start and stop together
        idle(5);
        cyc(1'b1, 1'b1, cur_loop);
        idle(3);
        launch(1'b0);                    // restart at phrase 3 step 2
        idle(40);
        launch(1'b0);
        idle(60);
        launch(1'b0);                    // restart from DONE
        idle(10);
        launch(1'b0);                    // back-to-back starts
        launch(1'b0);
        launch(1'b0);
        idle(55);
        cyc(1'b0, 1'b1, cur_loop);       // stop from DONE
        idle(3);
        launch(1'b1);                    // reset mid-playback
        idle(20);
        do_reset();
        idle(100);

        for (int i = 0; i < 3000; i++) begin
            bit st, sp;
            st = ($urandom_range(0, 63) == 0);
            sp = ($urandom_range(0, 127) == 0);
            if (st) cur_loop = $urandom_range(0, 1) == 1;
            cyc(st, sp, cur_loop);
        end

        @(posedge clk);
        #2;
        mon_en = 1'b0;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
